// File: rtl/alu_cb_pkg.sv
// Shared types and constants for the CB-prefix ALU sequencer.
// The encodings for bus output, latch load and shift select match the ALU include.
package alu_cb_pkg;

  // Sequencer states.
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t SEL_B  = 3'd1;
  localparam state_t LOAD_A = 3'd2;
  localparam state_t EXEC   = 3'd3;
  localparam state_t DONE   = 3'd4;

  // Opcode group field, bits [7:6] of the CB suffix byte.
  localparam logic [1:0] GRP_SH  = 2'b00;
  localparam logic [1:0] GRP_BIT = 2'b01;
  localparam logic [1:0] GRP_RES = 2'b10;
  localparam logic [1:0] GRP_SET = 2'b11;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BS_OE  = 2'd1,
    SH_OE  = 2'd2,
    RES_OE = 2'd3
  } oe_e;

  typedef enum logic {
    NO_LD  = 1'b0,
    BUS_LD = 1'b1
  } ld_e;

  typedef enum logic [2:0] {
    SH_RLC  = 3'd0,
    SH_RRC  = 3'd1,
    SH_RL   = 3'd2,
    SH_RR   = 3'd3,
    SH_SLA  = 3'd4,
    SH_SRA  = 3'd5,
    SH_SWAP = 3'd6,
    SH_SRL  = 3'd7
  } sh_e;

  // The 3-bit select has no spare code: "no shift" shares code 0 and the ALU
  // only applies the shifter when the mode word selects a shift (v=1).
  localparam sh_e NO_SH = SH_RLC;

  typedef struct packed {
    logic r;
    logic s;
    logic v;
    logic ne;
    logic ci;
    logic l;
    logic h;
  } alu_mode_t;

  // Mode words per op: _A while loading the operand, _E while executing.
  localparam alu_mode_t MODE_IDLE  = 7'b0000000;
  localparam alu_mode_t MODE_BIT_A = 7'b0100110;
  localparam alu_mode_t MODE_BIT_E = 7'b0100101;
  localparam alu_mode_t MODE_RES_A = 7'b1001010;
  localparam alu_mode_t MODE_RES_E = 7'b1001001;
  localparam alu_mode_t MODE_SET_A = 7'b1100010;
  localparam alu_mode_t MODE_SET_E = 7'b1100001;
  localparam alu_mode_t MODE_SH_A  = 7'b0010010;
  localparam alu_mode_t MODE_SH_E  = 7'b0010001;

  // Pick the mode word for the current op class and phase.
  function automatic alu_mode_t mode_sel(input logic is_bit, input logic is_res,
                                         input logic is_set, input logic exec);
    if (is_bit) return exec ? MODE_BIT_E : MODE_BIT_A;
    if (is_res) return exec ? MODE_RES_E : MODE_RES_A;
    if (is_set) return exec ? MODE_SET_E : MODE_SET_A;
    return exec ? MODE_SH_E : MODE_SH_A;
  endfunction

endpackage

// File: rtl/alu_cb_seq_decode.sv
// Combinational decode of the CB suffix byte (register field excluded).
module alu_cb_decode
  import alu_cb_pkg::*;
(
  input  logic [4:0] opc_hi,
  output logic       is_bit,
  output logic       is_res,
  output logic       is_set,
  output logic       is_sh,
  output logic [2:0] sh_kind,
  output logic [2:0] bsel
);

  // Split group and bit/shift field; [2:0] of opc_hi is opcode[5:3].
  always_comb begin
    is_bit  = (opc_hi[4:3] == GRP_BIT);
    is_res  = (opc_hi[4:3] == GRP_RES);
    is_set  = (opc_hi[4:3] == GRP_SET);
    is_sh   = (opc_hi[4:3] == GRP_SH);
    sh_kind = opc_hi[2:0];
    bsel    = opc_hi[2:0];
  end

endmodule

// File: rtl/alu_cb_seq.sv
// Multi-cycle sequencer driving the 8-bit ALU for CB-prefixed ops
// (BIT/RES/SET and the rotate/shift/swap group).
module alu_cb_seq
  import alu_cb_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  output logic       ready,
  input  logic [7:0] opcode,
  input  logic [7:0] operand,
  input  logic       cin,
  output logic [2:0] alu_bs,
  output logic [7:0] alu_op,
  output logic [2:0] alu_sh,
  output logic [1:0] alu_oe,
  output logic       alu_la,
  output logic       alu_lb,
  output logic [6:0] alu_mode,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] flags,
  output logic       wr
);

  state_t     state;
  logic [4:0] opc_q;
  logic [7:0] operand_q;
  logic       cin_q;
  logic       accept;
  logic       is_bit;
  logic       is_res;
  logic       is_set;
  logic       is_sh;
  logic [2:0] sh_kind;
  logic [2:0] bsel;
  logic       unused_reg_field;

  // The register field is resolved by the instruction decoder, not here.
  assign unused_reg_field = ^opcode[2:0];

  assign ready  = (state == IDLE);
  assign accept = start && ready;

  // Flag word produced at the end of EXEC.
  // RES/SET leave Z/N/H as they were; the decoder merges the real prior flags.
  function automatic logic [3:0] next_flags(input logic f_bit, input logic f_sh,
                                            input logic f_swap, input logic [3:0] prev,
                                            input logic z, input logic c, input logic ci);
    if (f_bit) return {z, 1'b0, 1'b1, ci};
    if (f_sh)  return {z, 2'b00, f_swap ? 1'b0 : c};
    return {prev[3:1], ci};
  endfunction

  alu_cb_decode u_decode (
    .opc_hi  (opc_q),
    .is_bit  (is_bit),
    .is_res  (is_res),
    .is_set  (is_set),
    .is_sh   (is_sh),
    .sh_kind (sh_kind),
    .bsel    (bsel)
  );

  // Capture the op on accept; held for the whole sequence.
  always_ff @(posedge clk) begin
    if (accept) begin
      opc_q     <= opcode[7:3];
      operand_q <= operand;
      cin_q     <= cin;
    end
  end

  // Sequencer state, done pulse and the registered result/flags/write-enable.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 8'h00;
      flags  <= 4'h0;
      wr     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= (opcode[7:6] == GRP_SH) ? LOAD_A : SEL_B;
        end
        SEL_B:  state <= LOAD_A;
        LOAD_A: state <= EXEC;
        EXEC: begin
          state  <= DONE;
          done   <= 1'b1;
          result <= alu_result;
          flags  <= next_flags(is_bit, is_sh, (sh_kind == SH_SWAP), flags,
                               alu_zero, alu_carry, cin_q);
          wr     <= ~is_bit;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ALU control lines decoded from the current state; idle outside an op.
  always_comb begin
    alu_bs   = 3'd0;
    alu_op   = 8'h00;
    alu_sh   = NO_SH;
    alu_oe   = NONE;
    alu_la   = NO_LD;
    alu_lb   = NO_LD;
    alu_mode = MODE_IDLE;
    case (state)
      SEL_B: begin
        alu_bs = bsel;
        alu_oe = BS_OE;
        alu_lb = BUS_LD;
      end
      LOAD_A: begin
        alu_op   = operand_q;
        alu_oe   = SH_OE;
        alu_la   = BUS_LD;
        alu_sh   = is_sh ? sh_kind : NO_SH;
        alu_mode = mode_sel(is_bit, is_res, is_set, 1'b0);
      end
      EXEC: begin
        alu_oe   = RES_OE;
        alu_mode = mode_sel(is_bit, is_res, is_set, 1'b1);
      end
      default: ;
    endcase
  end

  // A BIT test relies on the ALU holding carry high through load and execute.
  bit_carry_held: assert property (@(posedge clk) disable iff (!nreset)
    (is_bit && (state == LOAD_A || state == EXEC)) |-> alu_carry);

endmodule

// File: tb/tb_alu_cb_seq.sv
// Self-checking bench for alu_cb_seq with a behavioural ALU and a scoreboard.
module tb_alu_cb_seq;
  import alu_cb_pkg::*;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic [7:0] operand = 8'h00;
  logic       cin = 1'b0;
  logic       ready;
  logic [2:0] alu_bs;
  logic [7:0] alu_op;
  logic [2:0] alu_sh;
  logic [1:0] alu_oe;
  logic       alu_la;
  logic       alu_lb;
  logic [6:0] alu_mode;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;
  logic       wr;

  always #5 clk = ~clk;

  alu_cb_seq dut (
    .clk(clk), .nreset(nreset), .start(start), .ready(ready),
    .opcode(opcode), .operand(operand), .cin(cin),
    .alu_bs(alu_bs), .alu_op(alu_op), .alu_sh(alu_sh), .alu_oe(alu_oe),
    .alu_la(alu_la), .alu_lb(alu_lb), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .done(done), .result(result), .flags(flags), .wr(wr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    logic       wr;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mdl_flags = 4'h0;
  logic [7:0] last_res = 8'h00;
  logic [3:0] last_fl = 4'h0;
  logic       last_wr = 1'b0;

  // Behavioural ALU state
  logic [2:0] m_bs = 3'd0;
  logic [7:0] m_a = 8'h00;
  logic [2:0] m_sh = 3'd0;
  logic       cur_cin = 1'b0;
  logic [8:0] m_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {carry, result} of a CB shift-group op.
  function automatic logic [8:0] sh_calc(input logic [2:0] k, input logic [7:0] a, input logic c);
    case (k)
      3'd0:    return {a[7], a[6:0], a[7]};
      3'd1:    return {a[0], a[0], a[7:1]};
      3'd2:    return {a[7], a[6:0], c};
      3'd3:    return {a[0], c, a[7:1]};
      3'd4:    return {a[7], a[6:0], 1'b0};
      3'd5:    return {a[0], a[7], a[7:1]};
      3'd6:    return {a[7], a[3:0], a[7:4]};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  function automatic exp_t predict(input logic [7:0] opc, input logic [7:0] a, input logic c,
                                   input logic [3:0] prev, input int acc);
    exp_t e;
    logic [7:0] m;
    logic [8:0] s;
    m = 8'h01 << opc[5:3];
    e.acc = acc;
    e.lat = 4;
    e.wr  = 1'b1;
    case (opc[7:6])
      2'b01: begin
        e.res = a & m;
        e.fl  = {(e.res == 8'h00), 1'b0, 1'b1, c};
        e.wr  = 1'b0;
      end
      2'b10: begin
        e.res = a & ~m;
        e.fl  = {prev[3:1], c};
      end
      2'b11: begin
        e.res = a | m;
        e.fl  = {prev[3:1], c};
      end
      default: begin
        s     = sh_calc(opc[5:3], a, c);
        e.res = s[7:0];
        e.fl  = {(s[7:0] == 8'h00), 2'b00, (opc[5:3] == 3'd6) ? 1'b0 : s[8]};
        e.lat = 3;
      end
    endcase
    return e;
  endfunction

  // ALU latches
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_lb) m_bs <= alu_bs;
    if (alu_la) begin
      m_a  <= alu_op;
      m_sh <= alu_sh;
    end
  end

  // ALU result path
  always_comb begin
    m_s        = sh_calc(m_sh, m_a, cur_cin);
    alu_result = 8'h00;
    alu_carry  = alu_mode[2];
    if (alu_mode == MODE_BIT_E)      alu_result = m_a & (8'h01 << m_bs);
    else if (alu_mode == MODE_RES_E) alu_result = m_a & ~(8'h01 << m_bs);
    else if (alu_mode == MODE_SET_E) alu_result = m_a | (8'h01 << m_bs);
    else if (alu_mode == MODE_SH_E) begin
      alu_result = m_s[7:0];
      alu_carry  = m_s[8];
    end
    alu_zero = (alu_result == 8'h00);
  end

  // Scoreboard: push on accept, pop and compare on done
  always @(negedge clk) begin
    if (nreset) begin
      if (start && ready) begin
        exp_t e;
        e = predict(opcode, operand, cin, mdl_flags, cyc);
        mdl_flags = e.fl;
        cur_cin = cin;
        sb.push_back(e);
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        last_res = result;
        last_fl  = flags;
        last_wr  = wr;
        check("ready_in_done", ready, 0);
        if (sb.size() == 0) begin
          check("sb_entry", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("flags", flags, e.fl);
          check("wr", wr, e.wr);
          check("latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] opc, input logic [7:0] a, input logic c);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready", ready, 1);
    opcode = opc;
    operand = a;
    cin = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", (sb.size() == 0) && ready, 1);
  endtask

  task automatic trace_bit(input logic [2:0] b, input logic [7:0] a, input logic c);
    issue({2'b01, b, 3'b101}, a, c);
    @(negedge clk);
    check("selb_bs", alu_bs, b);
    check("selb_oe", alu_oe, BS_OE);
    check("selb_lb", alu_lb, 1);
    check("busy_ready", ready, 0);
    @(negedge clk);
    check("loada_op", alu_op, a);
    check("loada_oe", alu_oe, SH_OE);
    check("loada_la", alu_la, 1);
    check("loada_lb", alu_lb, 0);
    check("loada_sh", alu_sh, NO_SH);
    check("loada_mode", alu_mode, MODE_BIT_A);
    check("loada_carry", alu_carry, 1);
    @(negedge clk);
    check("exec_oe", alu_oe, RES_OE);
    check("exec_mode", alu_mode, MODE_BIT_E);
    check("exec_la", alu_la, 0);
    check("exec_carry", alu_carry, 1);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_oe", alu_oe, NONE);
    check("done_mode", alu_mode, 0);
    @(negedge clk);
    check("done_width", done, 0);
    check("ready_back", ready, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_wr"}, wr, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_flags"}, flags, 0);
    check({tag, "_oe"}, alu_oe, NONE);
    check({tag, "_la"}, alu_la, 0);
    check({tag, "_lb"}, alu_lb, 0);
    check({tag, "_sh"}, alu_sh, NO_SH);
    check({tag, "_mode"}, alu_mode, 0);
    check({tag, "_bs"}, alu_bs, 0);
    check({tag, "_op"}, alu_op, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int a0;
    int d0;
    logic [7:0] ro;
    logic [7:0] ra;
    logic       rc;

    #12;
    check_idle_outputs("rst");
    #10 nreset = 1'b1;

    trace_bit(3'd7, 8'h80, 1'b0);
    check("bit7_flags", last_fl, 4'b0010);
    check("bit7_wr", last_wr, 0);
    check("bit7_res", last_res, 8'h80);

    trace_bit(3'd3, 8'hF7, 1'b1);
    check("bit3_flags", last_fl, 4'b1011);
    check("bit3_wr", last_wr, 0);

    issue(8'h80 | (8'd0 << 3), 8'hFF, 1'b0);
    wait_idle();
    check("res0_res", last_res, 8'hFE);
    check("res0_wr", last_wr, 1);
    check("res0_flags", last_fl, 4'b1010);

    issue(8'hC0 | (8'd5 << 3), 8'h00, 1'b1);
    wait_idle();
    check("set5_res", last_res, 8'h20);
    check("set5_c", last_fl[0], 1);

    issue(8'h00 | 8'd2, 8'h85, 1'b0);
    wait_idle();
    check("rlc_res", last_res, 8'h0B);
    check("rlc_flags", last_fl, 4'b0001);

    issue(8'h30, 8'h00, 1'b1);
    wait_idle();
    check("swap0_flags", last_fl, 4'b1000);

    issue(8'h30, 8'h81, 1'b1);
    wait_idle();
    check("swap81_res", last_res, 8'h18);
    check("swap81_flags", last_fl, 4'b0000);

    for (int i = 0; i < 24; i++) begin
      ro = 8'($urandom);
      ra = 8'($urandom);
      rc = 1'($urandom);
      issue(ro, ra, rc);
      wait_idle();
    end

    // start held high: one bit op per 5-cycle window
    a0 = acc_cnt;
    @(posedge clk); #1;
    opcode = 8'h40 | (8'd2 << 3);
    operand = 8'h04;
    cin = 1'b0;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("held_start_accepts", acc_cnt - a0, 4);

    // reset during EXEC aborts without a done
    issue(8'h40 | (8'd4 << 3), 8'h10, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (alu_oe != RES_OE && n < 10);
    check("reach_exec", alu_oe, RES_OE);
    #1 nreset = 1'b0;
    d0 = done_cnt;
    #1 check_idle_outputs("abort");
    sb.delete();
    mdl_flags = 4'h0;
    repeat (3) @(posedge clk);
    #2 nreset = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_ready", ready, 1);

    issue(8'h38 | 8'd1, 8'h03, 1'b0);
    wait_idle();
    check("post_abort_res", last_res, 8'h01);
    check("post_abort_flags", last_fl, 4'b0001);
    check("post_abort_done", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
